// File: rtl/key_pkg.sv
// Shared definitions for the active-low key encoder: line count, code width
// and the encoder FSM state type.
package key_pkg;

  localparam int unsigned NUM_KEYS = 8;
  localparam int unsigned CODE_W   = 3;
  localparam logic [NUM_KEYS-1:0] KEYS_NONE = 8'hFF;

  typedef enum logic {
    IDLE = 1'b0,
    HELD = 1'b1
  } state_t;

endpackage

// File: rtl/vec_debounce.sv
// Two-flop synchroniser plus whole-vector debouncer for active-low switch banks;
// the output only moves after the synchronised vector is stable for DEBOUNCE_CYCLES clocks.
module vec_debounce #(
  parameter int unsigned WIDTH           = 8,
  parameter int unsigned DEBOUNCE_CYCLES = 4
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic [WIDTH-1:0] raw_i,
  output logic [WIDTH-1:0] deb_o
);

  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

  logic [WIDTH-1:0] s1_q, s2_q, s3_q;
  logic [WIDTH-1:0] deb_q, deb_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    deb_d = deb_q;
    if (s2_q != s3_q) begin
      cnt_d = '0;
    end else begin
      if (cnt_q != CNT_W'(DEBOUNCE_CYCLES))
        cnt_d = cnt_q + CNT_W'(1);
      // Accept on the last stable cycle so acceptance lands exactly DEBOUNCE_CYCLES after s3 settles.
      if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1))
        deb_d = s2_q;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      s1_q  <= '1;
      s2_q  <= '1;
      s3_q  <= '1;
      deb_q <= '1;
      cnt_q <= '0;
    end else begin
      s1_q  <= raw_i;
      s2_q  <= s1_q;
      s3_q  <= s2_q;
      deb_q <= deb_d;
      cnt_q <= cnt_d;
    end
  end

  assign deb_o = deb_q;

endmodule

// File: rtl/key_encoder_8to3.sv
// Debounced 8-line active-low key encoder: lowest pressed index wins, with
// registered code, valid level, press/release strobes and multi-key flag.
module key_encoder_8to3
  import key_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 4
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic [NUM_KEYS-1:0] KEY,
  input  logic              ENABLE,
  output logic [CODE_W-1:0] CODE,
  output logic              VALID,
  output logic              PRESS,
  output logic              RELEASE,
  output logic              MULTI
);

  logic [NUM_KEYS-1:0] deb;
  logic [NUM_KEYS-1:0] pressed;
  logic [CODE_W-1:0]   code_next;
  logic                any_key, multi_key;

  state_t              state_q, state_d;
  logic [CODE_W-1:0]   code_q, code_d;
  logic                valid_q, valid_d;
  logic                press_q, press_d;
  logic                release_q, release_d;
  logic                multi_q, multi_d;

  vec_debounce #(
    .WIDTH          (NUM_KEYS),
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_deb (
    .CLK  (CLK),
    .RST_N(RST_N),
    .raw_i(KEY),
    .deb_o(deb)
  );

  assign pressed   = ~deb;
  assign any_key   = (deb != KEYS_NONE);
  // Clearing the lowest set bit leaves something only if two or more keys are down.
  assign multi_key = ((pressed & (pressed - NUM_KEYS'(1))) != '0);

  always_comb begin
    code_next = '0;
    for (int unsigned i = NUM_KEYS; i > 0; i--) begin
      if (pressed[i-1])
        code_next = CODE_W'(i - 1);
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (ENABLE) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    if (any_key)  state_d = HELD;
        HELD:    if (!any_key) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // Disabling out of HELD takes the ENABLE path, so it never raises RELEASE.
  always_comb begin
    press_d   = (state_q == IDLE) && (state_d == HELD);
    release_d = (state_q == HELD) && (state_d == IDLE) && !ENABLE;
    valid_d   = (state_d == HELD);
    multi_d   = !ENABLE && multi_key;
    code_d    = press_d ? code_next : code_q;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      code_q    <= '0;
      valid_q   <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      multi_q   <= 1'b0;
    end else begin
      code_q    <= code_d;
      valid_q   <= valid_d;
      press_q   <= press_d;
      release_q <= release_d;
      multi_q   <= multi_d;
    end
  end

  assign CODE    = code_q;
  assign VALID   = valid_q;
  assign PRESS   = press_q;
  assign RELEASE = release_q;
  assign MULTI   = multi_q;

endmodule

// File: tb/tb_key_encoder_8to3.sv
// Directed self-checking bench for key_encoder_8to3 with DEBOUNCE_CYCLES=4
// (clean key edge to strobe latency of 7 clocks).
module tb_key_encoder_8to3;

  logic       CLK = 1'b0;
  logic       RST_N;
  logic [7:0] KEY;
  logic       ENABLE;
  logic [2:0] CODE;
  logic       VALID, PRESS, RELEASE, MULTI;

  int tests_run    = 0;
  int tests_failed = 0;

  always #5 CLK = ~CLK;

  key_encoder_8to3 #(.DEBOUNCE_CYCLES(4)) dut (
    .CLK    (CLK),
    .RST_N  (RST_N),
    .KEY    (KEY),
    .ENABLE (ENABLE),
    .CODE   (CODE),
    .VALID  (VALID),
    .PRESS  (PRESS),
    .RELEASE(RELEASE),
    .MULTI  (MULTI)
  );

  // Advance n rising edges and settle 1 time unit past the last one.
  task automatic step(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic test_reset();
    logic [6:0] outs;
    RST_N  = 1'b0;
    KEY    = 8'h00;
    ENABLE = 1'b0;
    #2;
    for (int i = 0; i < 6; i++) begin
      outs = {CODE, VALID, PRESS, RELEASE, MULTI};
      tests_run++;
      if (outs !== 7'b0) begin
        tests_failed++;
        $display("FAIL reset_hold cycle %0d: outputs=%b required=%b", i, outs, 7'b0);
      end
      step(1);
    end
    KEY   = 8'hFF;
    RST_N = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step(1);
      tests_run++;
      if ({VALID, PRESS, RELEASE, MULTI} !== 4'b0) begin
        tests_failed++;
        $display("FAIL reset_release cycle %0d: V/P/R/M=%b required=0000", i,
                 {VALID, PRESS, RELEASE, MULTI});
      end
    end
  endtask

  task automatic test_clean_press();
    KEY = 8'hFB;
    step(7);
    tests_run++;
    if (PRESS !== 1'b0 || VALID !== 1'b0) begin
      tests_failed++;
      $display("FAIL press_early: PRESS=%b VALID=%b required 0 0", PRESS, VALID);
    end
    step(1);
    tests_run++;
    if (PRESS !== 1'b1 || VALID !== 1'b1 || CODE !== 3'd2) begin
      tests_failed++;
      $display("FAIL press_k7: PRESS=%b VALID=%b CODE=%0d required 1 1 2", PRESS, VALID, CODE);
    end
    step(1);
    tests_run++;
    if (PRESS !== 1'b0 || VALID !== 1'b1) begin
      tests_failed++;
      $display("FAIL press_single: PRESS=%b VALID=%b required 0 1", PRESS, VALID);
    end
    step(3);
    KEY = 8'hFF;
    step(7);
    tests_run++;
    if (RELEASE !== 1'b0 || VALID !== 1'b1) begin
      tests_failed++;
      $display("FAIL release_early: RELEASE=%b VALID=%b required 0 1", RELEASE, VALID);
    end
    step(1);
    tests_run++;
    if (RELEASE !== 1'b1 || VALID !== 1'b0 || CODE !== 3'd2 || PRESS !== 1'b0) begin
      tests_failed++;
      $display("FAIL release_k7: RELEASE=%b VALID=%b CODE=%0d PRESS=%b required 1 0 2 0",
               RELEASE, VALID, CODE, PRESS);
    end
    step(1);
    tests_run++;
    if (RELEASE !== 1'b0 || CODE !== 3'd2) begin
      tests_failed++;
      $display("FAIL release_single: RELEASE=%b CODE=%0d required 0 2", RELEASE, CODE);
    end
    step(3);
  endtask

  task automatic test_bounce();
    int presses = 0;
    for (int seg = 0; seg < 6; seg++) begin
      KEY = (seg % 2 == 0) ? 8'hEF : 8'hFF;
      for (int c = 0; c < 2; c++) begin
        step(1);
        if (PRESS === 1'b1) presses++;
      end
    end
    KEY = 8'hEF;
    for (int c = 0; c < 7; c++) begin
      step(1);
      if (PRESS === 1'b1) presses++;
    end
    tests_run++;
    if (presses !== 0) begin
      tests_failed++;
      $display("FAIL bounce_early: presses=%0d required 0", presses);
    end
    step(1);
    tests_run++;
    if (PRESS !== 1'b1 || CODE !== 3'd4) begin
      tests_failed++;
      $display("FAIL bounce_press: PRESS=%b CODE=%0d required 1 4", PRESS, CODE);
    end
    presses = 0;
    for (int c = 0; c < 10; c++) begin
      step(1);
      if (PRESS === 1'b1) presses++;
    end
    tests_run++;
    if (presses !== 0) begin
      tests_failed++;
      $display("FAIL bounce_extra: presses=%0d required 0", presses);
    end
    KEY = 8'hFF;
    step(10);
  endtask

  task automatic test_multi();
    int presses = 0;
    KEY = 8'h5F;
    step(8);
    tests_run++;
    if (PRESS !== 1'b1 || CODE !== 3'd5 || MULTI !== 1'b1) begin
      tests_failed++;
      $display("FAIL multi_press: PRESS=%b CODE=%0d MULTI=%b required 1 5 1", PRESS, CODE, MULTI);
    end
    step(2);
    KEY = 8'h7F;
    for (int c = 0; c < 8; c++) begin
      step(1);
      if (PRESS === 1'b1) presses++;
    end
    tests_run++;
    if (presses !== 0 || CODE !== 3'd5 || VALID !== 1'b1 || MULTI !== 1'b0) begin
      tests_failed++;
      $display("FAIL multi_change: presses=%0d CODE=%0d VALID=%b MULTI=%b required 0 5 1 0",
               presses, CODE, VALID, MULTI);
    end
    KEY = 8'hFF;
    step(10);
  endtask

  task automatic test_enable();
    int rel = 0;
    KEY = 8'hFD;
    step(8);
    tests_run++;
    if (PRESS !== 1'b1 || CODE !== 3'd1) begin
      tests_failed++;
      $display("FAIL en_press: PRESS=%b CODE=%0d required 1 1", PRESS, CODE);
    end
    step(2);
    ENABLE = 1'b1;
    step(1);
    tests_run++;
    if ({VALID, PRESS, RELEASE, MULTI} !== 4'b0) begin
      tests_failed++;
      $display("FAIL en_disable: V/P/R/M=%b required 0000", {VALID, PRESS, RELEASE, MULTI});
    end
    for (int c = 0; c < 4; c++) begin
      step(1);
      if (RELEASE === 1'b1 || VALID === 1'b1) rel++;
    end
    tests_run++;
    if (rel !== 0 || CODE !== 3'd1) begin
      tests_failed++;
      $display("FAIL en_held_off: release_or_valid=%0d CODE=%0d required 0 1", rel, CODE);
    end
    ENABLE = 1'b0;
    step(1);
    tests_run++;
    if (PRESS !== 1'b1 || VALID !== 1'b1 || CODE !== 3'd1) begin
      tests_failed++;
      $display("FAIL en_reenable: PRESS=%b VALID=%b CODE=%0d required 1 1 1", PRESS, VALID, CODE);
    end
    step(1);
    tests_run++;
    if (PRESS !== 1'b0) begin
      tests_failed++;
      $display("FAIL en_reenable_single: PRESS=%b required 0", PRESS);
    end
  endtask

  // Entered with key 1 held and the encoder in HELD.
  task automatic test_midreset();
    int strobes = 0;
    #3;
    RST_N = 1'b0;
    #1;
    tests_run++;
    if ({CODE, VALID, PRESS, RELEASE, MULTI} !== 7'b0) begin
      tests_failed++;
      $display("FAIL async_reset: outputs=%b required %b", {CODE, VALID, PRESS, RELEASE, MULTI}, 7'b0);
    end
    step(3);
    RST_N = 1'b1;
    for (int c = 0; c < 7; c++) begin
      step(1);
      if (PRESS === 1'b1 || RELEASE === 1'b1) strobes++;
    end
    tests_run++;
    if (strobes !== 0) begin
      tests_failed++;
      $display("FAIL reset_no_strobe: strobes=%0d required 0", strobes);
    end
    step(1);
    tests_run++;
    if (PRESS !== 1'b1 || CODE !== 3'd1 || VALID !== 1'b1) begin
      tests_failed++;
      $display("FAIL reset_repress: PRESS=%b CODE=%0d VALID=%b required 1 1 1", PRESS, CODE, VALID);
    end
    KEY = 8'hFF;
    step(10);
  endtask

  initial begin
    test_reset();
    test_clean_press();
    test_bounce();
    test_multi();
    test_enable();
    test_midreset();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/key_encoder_8to3.md
Name: key_encoder_8to3

Overview:
Encodes 8 active-low key or switch inputs into a 3-bit key code. It is the input-side counterpart of the 3-to-8 active-low LED decoder: code N corresponds to line N, bit 0 maps to code 0. Inputs are synchronised, debounced as a vector and priority-encoded, lowest index wins. A registered code is produced with press/release strobes for downstream logic, for example driving the LED decoder directly.

Parameters:
DEBOUNCE_CYCLES, 4, consecutive clocks the synchronised vector must be unchanged before it is accepted (≥2; board builds use 250000).
CNT_W, $clog2(DEBOUNCE_CYCLES+1), debounce counter width; derived, not overridden.

Ports:
CLK  input  1  system clock
RST_N  input  1  asynchronous active-low reset
KEY  input  8  raw key lines, active-low (0 = pressed), asynchronous to CLK
ENABLE  input  1  active-low enable, synchronous (0 = encoder active)
CODE  output  3  index of lowest-numbered pressed key, held while VALID
VALID  output  1  high while a debounced key press is held
PRESS  output  1  one-cycle strobe on accepted new press
RELEASE  output  1  one-cycle strobe when all keys released after a press
MULTI  output  1  high while more than one debounced key is pressed

Behaviour:
- Clock and reset: one clock, CLK. Reset is asynchronous and active-low on RST_N. All flops clear on RST_N=0.
- Reset values:
  - CODE=3'b000, VALID=0, PRESS=0, RELEASE=0, MULTI=0.
  - Synchroniser and debounced vector reset to 8'hFF (no key pressed).
  - Counter resets to 0. FSM resets to IDLE.
- Synchroniser: 2-flop on all 8 KEY bits (s1, s2).
- Debounce:
  - Register s3 <= s2 every cycle.
  - If s2 != s3, counter <= 0. Otherwise counter increments, saturating at DEBOUNCE_CYCLES.
  - When counter == DEBOUNCE_CYCLES-1 and s2 == s3, deb <= s2.
  - Any bounce restarts the count. Glitches shorter than DEBOUNCE_CYCLES clocks never reach deb.
- Priority encode of ~deb: CODE_next = lowest index i with deb[i]==0.
  - any = (deb != 8'hFF).
  - multi = more than one zero bit in deb.
- FSM states, registered outputs:
  - IDLE: VALID=0. On any=1 (and ENABLE=0): CODE<=CODE_next, VALID<=1, PRESS<=1 for one cycle, go to HELD.
  - HELD: VALID=1, CODE frozen. A change in the pressed set does not update CODE or re-fire PRESS. On any=0: VALID<=0, RELEASE<=1 for one cycle, go to IDLE. CODE keeps its last value.
  - MULTI tracks multi every cycle while ENABLE=0, and is 0 otherwise.
- Latency: a clean KEY transition first sampled at edge k produces PRESS/VALID (or RELEASE) high after edge k+DEBOUNCE_CYCLES+3. It is exactly reproducible for clean stimulus.
- ENABLE=1 (disabled):
  - The synchroniser and debounce keep running.
  - FSM is forced to IDLE. VALID, PRESS, RELEASE and MULTI are 0. CODE holds its value.
  - No RELEASE fires when disabling during HELD.
  - On re-enable with a key already held, the press is accepted one cycle later (PRESS fires).
- Simultaneous presses within the debounce window resolve to the lowest index, with MULTI=1.
- Press and release never strobe in the same cycle. PRESS and RELEASE are mutually exclusive.
- RST_N asserted mid-debounce or in HELD: immediate clear to reset values. No strobe on reset release, even if a key is held; the key is then re-debounced and produces PRESS.

Decomposition:
- Shared package key_pkg:
  - FSM state typedef (IDLE, HELD).
  - KEYS_NONE = 8'hFF.
  - NUM_KEYS = 8.
  - CODE_W = 3.
- Sub-module vec_debounce: parameters WIDTH, DEBOUNCE_CYCLES. Ports CLK, RST_N, raw in, deb out. It contains the synchroniser, s3 and the counter, and is reusable for other switch banks.
- The top holds the priority encoder, FSM and strobes.

Test Plan:
- Reset: hold RST_N=0 with KEY=8'h00 → all outputs 0 throughout. Release reset with KEY=8'hFF → no strobe for 20 cycles.
- Clean press/release: ENABLE=0, KEY=8'hFB from edge k → PRESS single cycle and VALID=1, CODE=3'd2 at edge k+7. KEY=8'hFF later → RELEASE single cycle at +7, VALID=0, CODE stays 2.
- Bounce: KEY toggles 8'hEF/8'hFF every 2 cycles for 12 cycles, then holds 8'hEF → exactly one PRESS, 7 cycles after the last toggle, with CODE=3'd4.
- Multi-key: KEY=8'h5F (keys 5 and 7) → CODE=3'd5, MULTI=1. Then KEY=8'h7F → CODE stays 5, no PRESS, MULTI=0.
- Enable gating: in HELD with CODE=3'd1, set ENABLE=1 → VALID=0 next cycle, no RELEASE. Set ENABLE=0 with key still held → PRESS one cycle later, CODE=3'd1.
- Mid-operation reset: assert RST_N=0 asynchronously during HELD → outputs clear before the next CLK edge. Deassert with key held → PRESS after DEBOUNCE_CYCLES+3 cycles.
